// File: rtl/psr_cond_unit.sv
// Processor status register with flag updates and a one-entry condition result buffer.
// Optional shadow PSR (save/restore/swap) enabled by defining PSR_SHADOW_EN.
module psr_cond_unit #(
    parameter logic [15:0] PSR_MASK = 16'h00E5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] flags_in,
    input  logic [4:0]  flag_we,
    input  logic        psr_wr_en,
    input  logic [15:0] psr_wr_data,
`ifdef PSR_SHADOW_EN
    input  logic        save_req,
    input  logic        restore_req,
`endif
    input  logic        cond_valid,
    input  logic [3:0]  cond_code,
    output logic        cond_ready,
    output logic        take_valid,
    output logic        take,
    input  logic        take_ack,
    output logic [15:0] psr_out
);

    localparam int N_BIT = 7;
    localparam int Z_BIT = 6;
    localparam int F_BIT = 5;
    localparam int L_BIT = 2;
    localparam int C_BIT = 0;

    logic [15:0] psr_q;
    logic [15:0] psr_d;
    logic [15:0] we_mask;
    logic        accept;
    logic        cond_true;
    logic        n, z, f, l, c;

`ifdef PSR_SHADOW_EN
    logic [15:0] shadow_q;
`endif

    // Spread the compact per-flag enables onto PSR bit positions
    always_comb begin
        we_mask        = '0;
        we_mask[N_BIT] = flag_we[4];
        we_mask[Z_BIT] = flag_we[3];
        we_mask[F_BIT] = flag_we[2];
        we_mask[L_BIT] = flag_we[1];
        we_mask[C_BIT] = flag_we[0];
    end

    // Lowest priority first so later assignments win
    always_comb begin
        psr_d = (psr_q & ~we_mask) | (flags_in & we_mask);
        if (psr_wr_en) begin
            psr_d = psr_wr_data;
        end
`ifdef PSR_SHADOW_EN
        if (restore_req) begin
            psr_d = shadow_q;
        end
`endif
        psr_d = psr_d & PSR_MASK;
    end

    assign n = psr_d[N_BIT];
    assign z = psr_d[Z_BIT];
    assign f = psr_d[F_BIT];
    assign l = psr_d[L_BIT];
    assign c = psr_d[C_BIT];

    // Evaluated on the forwarded PSR so same-edge flag writes are seen
    always_comb begin
        cond_true = 1'b0;
        unique case (cond_code)
            4'h0: cond_true = z;
            4'h1: cond_true = !z;
            4'h2: cond_true = c;
            4'h3: cond_true = !c;
            4'h4: cond_true = l;
            4'h5: cond_true = !l;
            4'h6: cond_true = n;
            4'h7: cond_true = !n;
            4'h8: cond_true = f;
            4'h9: cond_true = !f;
            4'hA: cond_true = !l && !z;
            4'hB: cond_true = l || z;
            4'hC: cond_true = !n && !z;
            4'hD: cond_true = n || z;
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
        endcase
    end

    assign cond_ready = !take_valid || take_ack;
    assign accept     = cond_valid && cond_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            take_valid <= 1'b0;
            take       <= 1'b0;
        end else if (accept) begin
            take_valid <= 1'b1;
            take       <= cond_true;
        end else if (take_ack) begin
            take_valid <= 1'b0;
            take       <= 1'b0;
        end
    end

`ifdef PSR_SHADOW_EN
    // Captures the PSR before this edge's update, which makes save+restore a swap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (save_req) begin
            shadow_q <= psr_q;
        end
    end
`endif

    assign psr_out = psr_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Self-checking bench for psr_cond_unit; exercises the shadow PSR
// when PSR_SHADOW_EN is defined.
module tb_psr_cond_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] flags_in;
    logic [4:0]  flag_we;
    logic        psr_wr_en;
    logic [15:0] psr_wr_data;
    logic        cond_valid;
    logic [3:0]  cond_code;
    logic        cond_ready;
    logic        take_valid;
    logic        take;
    logic        take_ack;
    logic [15:0] psr_out;
`ifdef PSR_SHADOW_EN
    logic        save_req;
    logic        restore_req;
`endif

    int checks = 0;
    int errors = 0;
    bit run = 0;

    psr_cond_unit dut (
        .clk(clk),
        .reset(reset),
        .flags_in(flags_in),
        .flag_we(flag_we),
        .psr_wr_en(psr_wr_en),
        .psr_wr_data(psr_wr_data),
`ifdef PSR_SHADOW_EN
        .save_req(save_req),
        .restore_req(restore_req),
`endif
        .cond_valid(cond_valid),
        .cond_code(cond_code),
        .cond_ready(cond_ready),
        .take_valid(take_valid),
        .take(take),
        .take_ack(take_ack),
        .psr_out(psr_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: individual flags plus a result slot
    bit m_n, m_z, m_f, m_l, m_c;
    bit m_tv, m_take;
    logic [15:0] m_sh;

    function automatic logic [15:0] word(bit n, bit z, bit f, bit l, bit c);
        return {8'b0, n, z, f, 2'b00, l, 1'b0, c};
    endfunction

    function automatic bit holds(int code, bit n, bit z, bit f, bit l, bit c);
        case (code)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return l;
            5: return !l;
            6: return n;
            7: return !n;
            8: return f;
            9: return !f;
            10: return !l && !z;
            11: return l || z;
            12: return !n && !z;
            13: return n || z;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        bit n, z, f, l, c;
        logic [15:0] w;
        if (reset) begin
            {m_n, m_z, m_f, m_l, m_c} = '0;
            m_tv = 0;
            m_take = 0;
            m_sh = '0;
        end else begin
            {n, z, f, l, c} = {m_n, m_z, m_f, m_l, m_c};
            if (flag_we[4]) n = flags_in[7];
            if (flag_we[3]) z = flags_in[6];
            if (flag_we[2]) f = flags_in[5];
            if (flag_we[1]) l = flags_in[2];
            if (flag_we[0]) c = flags_in[0];
            if (psr_wr_en) begin
                w = psr_wr_data;
                {n, z, f, l, c} = {w[7], w[6], w[5], w[2], w[0]};
            end
`ifdef PSR_SHADOW_EN
            if (restore_req) {n, z, f, l, c} = {m_sh[7], m_sh[6], m_sh[5], m_sh[2], m_sh[0]};
            if (save_req) m_sh = word(m_n, m_z, m_f, m_l, m_c);
`endif
            if (cond_valid && (!m_tv || take_ack)) begin
                m_tv = 1;
                m_take = holds(int'(cond_code), n, z, f, l, c);
            end else if (take_ack) begin
                m_tv = 0;
            end
            {m_n, m_z, m_f, m_l, m_c} = {n, z, f, l, c};
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("psr_out", psr_out, word(m_n, m_z, m_f, m_l, m_c));
            chk("take_valid", 16'(take_valid), 16'(m_tv));
            chk("cond_ready", 16'(cond_ready), 16'(!m_tv || take_ack));
            if (m_tv) chk("take", 16'(take), 16'(m_take));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [3:0] code, input logic ack);
        cond_valid = 1'b1;
        cond_code  = code;
        take_ack   = ack;
    endtask

    task automatic idle();
        flag_we    = '0;
        psr_wr_en  = 1'b0;
        cond_valid = 1'b0;
        take_ack   = 1'b0;
    endtask

    logic [15:0] pats [9] = '{16'h0000, 16'h0040, 16'h0001, 16'h0004,
                              16'h0080, 16'h0020, 16'h0044, 16'h00E5, 16'h00A1};

    initial begin
        reset = 1'b1;
        flags_in = '0;
        psr_wr_data = '0;
        cond_code = '0;
        idle();
`ifdef PSR_SHADOW_EN
        save_req = 1'b0;
        restore_req = 1'b0;
`endif
        tick();
        tick();
        run = 1;
        chk("rst_psr", psr_out, 16'h0000);
        chk("rst_tv", 16'(take_valid), 16'h0);
        chk("rst_ready", 16'(cond_ready), 16'h1);
        reset = 1'b0;
        tick();

        flags_in = 16'h00E5; flag_we = 5'b11111;
        tick();
        chk("flags_all", psr_out, 16'h00E5);
        flags_in = 16'h0000; flag_we = 5'b00001;
        tick();
        chk("flag_c_only", psr_out, 16'h00E4);
        idle();

        req(4'h0, 1'b0);
        tick();
        chk("eq_tv", 16'(take_valid), 16'h1);
        chk("eq_take", 16'(take), 16'h1);
        req(4'h1, 1'b1);
        tick();
        chk("ne_take", 16'(take), 16'h0);
        idle(); take_ack = 1'b1;
        tick();
        chk("ack_clear", 16'(take_valid), 16'h0);

        idle(); flag_we = 5'b01000; flags_in = 16'h0000;
        tick();
        flags_in = 16'h0040; req(4'h0, 1'b0);
        tick();
        chk("fwd_take", 16'(take), 16'h1);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_tv", 16'(take_valid), 16'h1);
            chk("hold_ready", 16'(cond_ready), 16'h0);
        end
        req(4'hF, 1'b1);
        tick();
        chk("b2b_tv", 16'(take_valid), 16'h1);
        chk("b2b_take", 16'(take), 16'h0);
        req(4'hE, 1'b1);
        tick();
        chk("b2b_take2", 16'(take), 16'h1);
        idle(); take_ack = 1'b1;
        tick();
        tick();
        chk("ack_idle", 16'(take_valid), 16'h0);

        foreach (pats[p]) begin
            idle();
            psr_wr_en = 1'b1; psr_wr_data = pats[p];
            for (int k = 0; k < 16; k++) begin
                req(4'(k), 1'b1);
                tick();
                psr_wr_en = 1'b0;
            end
        end

        idle(); psr_wr_en = 1'b1; psr_wr_data = 16'h0004; req(4'h4, 1'b1);
        tick();
        chk("hi_take", 16'(take), 16'h1);
        psr_wr_en = 1'b0; req(4'hA, 1'b1);
        tick();
        chk("lo_take", 16'(take), 16'h0);
        req(4'hB, 1'b1);
        tick();
        chk("hs_take", 16'(take), 16'h1);

        idle(); psr_wr_en = 1'b1; psr_wr_data = 16'hFFFF;
        flag_we = 5'b11111; flags_in = 16'h0000; take_ack = 1'b1;
        tick();
        chk("wr_prio", psr_out, 16'h00E5);

        idle(); req(4'hE, 1'b0);
        tick();
        idle();
        chk("pre_rst_tv", 16'(take_valid), 16'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_tv", 16'(take_valid), 16'h0);
        chk("mid_rst_psr", psr_out, 16'h0000);
        chk("mid_rst_ready", 16'(cond_ready), 16'h1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_tv", 16'(take_valid), 16'h0);

`ifdef PSR_SHADOW_EN
        idle(); psr_wr_en = 1'b1; psr_wr_data = 16'h0041;
        tick();
        psr_wr_en = 1'b0; save_req = 1'b1;
        tick();
        save_req = 1'b0; psr_wr_en = 1'b1; psr_wr_data = 16'h0080;
        tick();
        chk("sh_over", psr_out, 16'h0080);
        psr_wr_en = 1'b0; restore_req = 1'b1;
        tick();
        chk("sh_restore", psr_out, 16'h0041);
        restore_req = 1'b0; psr_wr_en = 1'b1; psr_wr_data = 16'h0020;
        tick();
        psr_wr_en = 1'b0; save_req = 1'b1; restore_req = 1'b1;
        tick();
        chk("sh_swap", psr_out, 16'h0041);
        save_req = 1'b0;
        tick();
        chk("sh_swap_back", psr_out, 16'h0020);
        restore_req = 1'b0;
        tick();
`endif

        idle();
        tick();
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
